// File: rtl/dmac_ahb_slv_regs.sv
// AHB-lite responder for the DMAC slave register port: channel config/status bank
// with configurable wait states and a two-cycle ERROR response for bad addresses.
module dmac_ahb_slv_regs #(
   parameter int WAIT_STATES = 1,
   parameter int ADDR_W      = 8
) (
   input  logic        hclk,
   input  logic        hrst_n,
   input  logic        s_hsel,
   input  logic [31:0] s_haddr,
   input  logic [1:0]  s_htrans,
   input  logic        s_hwrite,
   input  logic [3:0]  s_hprot,
   input  logic [31:0] s_hwdata,
   output logic [31:0] s_hrdata,
   output logic        s_hready,
   output logic [1:0]  s_hresp,
   input  logic        ch_busy,
   input  logic        ch_done,
   output logic [31:0] cfg_src,
   output logic [31:0] cfg_dst,
   output logic [15:0] cfg_len,
   output logic        ch_start,
   output logic        irq
);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

   localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   localparam logic [2:0] R_SCR0 = 3'd0, R_SCR1 = 3'd1, R_SRC  = 3'd2, R_DST = 3'd3,
                          R_LEN  = 3'd4, R_CTRL = 3'd5, R_STAT = 3'd6;

   state_t            st, nxt;
   logic [CW-1:0]     cnt;
   logic [2:0]        a_idx;
   logic              a_wr, a_bad;
   logic              accept, dec_bad, commit_wr, rd_phase;
   logic [ADDR_W-1:0] offset;
   logic [31:0]       scratch0, scratch1, rd_mux, hrdata_q;
   logic              int_en, done_flag;
   logic              unused_ok;

   // upper haddr bits, hprot and htrans[0] carry no meaning for this port
   assign unused_ok = &{1'b0, s_hprot, s_haddr[31:ADDR_W], s_htrans[0]};

   assign accept    = s_hsel & s_htrans[1] & s_hready;
   assign offset    = s_haddr[ADDR_W-1:0];
   assign dec_bad   = (s_haddr[1:0] != 2'b00) || (offset >= ADDR_W'(28));
   assign commit_wr = (st == S_DATA) & a_wr;
   assign rd_phase  = (st == S_DATA) & ~a_wr;

   always_ff @(posedge hclk or negedge hrst_n) begin
      if (!hrst_n) begin
         st  <= S_IDLE;
         cnt <= '0;
      end else begin
         st  <= nxt;
         cnt <= (st == S_WAIT) ? cnt + 1'b1 : '0;
      end
   end

   always_comb begin
      nxt = st;
      unique case (st)
         S_WAIT:  if (cnt == CNT_LAST) nxt = a_bad ? S_ERR1 : S_DATA;
         S_ERR1:  nxt = S_ERR2;
         default: begin
            if (!accept)              nxt = S_IDLE;
            else if (WAIT_STATES > 0) nxt = S_WAIT;
            else                      nxt = dec_bad ? S_ERR1 : S_DATA;
         end
      endcase
   end

   always_comb begin
      s_hready = 1'b1;
      s_hresp  = 2'b00;
      unique case (st)
         S_WAIT:  s_hready = 1'b0;
         S_ERR1:  begin s_hready = 1'b0; s_hresp = 2'b01; end
         S_ERR2:  s_hresp = 2'b01;
         default: ;
      endcase
   end

   always_ff @(posedge hclk or negedge hrst_n) begin
      if (!hrst_n) begin
         a_idx <= '0;
         a_wr  <= 1'b0;
         a_bad <= 1'b0;
      end else if (accept) begin
         a_idx <= s_haddr[4:2];
         a_wr  <= s_hwrite;
         a_bad <= dec_bad;
      end
   end

   always_comb begin
      rd_mux = '0;
      unique case (a_idx)
         R_SCR0:  rd_mux = scratch0;
         R_SCR1:  rd_mux = scratch1;
         R_SRC:   rd_mux = cfg_src;
         R_DST:   rd_mux = cfg_dst;
         R_LEN:   rd_mux = {16'h0, cfg_len};
         R_CTRL:  rd_mux = {30'h0, int_en, 1'b0};
         R_STAT:  rd_mux = {30'h0, done_flag, ch_busy};
         default: rd_mux = '0;
      endcase
   end

   // read data is live in the final cycle, then held until the next read ends
   assign s_hrdata = rd_phase ? rd_mux : hrdata_q;

   always_ff @(posedge hclk or negedge hrst_n) begin
      if (!hrst_n) begin
         scratch0  <= '0;
         scratch1  <= '0;
         cfg_src   <= '0;
         cfg_dst   <= '0;
         cfg_len   <= '0;
         int_en    <= 1'b0;
         done_flag <= 1'b0;
         ch_start  <= 1'b0;
         irq       <= 1'b0;
         hrdata_q  <= '0;
      end else begin
         ch_start <= commit_wr && (a_idx == R_CTRL) && s_hwdata[0] && !ch_busy;
         irq      <= done_flag & int_en;
         if (rd_phase) hrdata_q <= rd_mux;
         if (commit_wr) begin
            unique case (a_idx)
               R_SCR0:  scratch0 <= s_hwdata;
               R_SCR1:  scratch1 <= s_hwdata;
               R_SRC:   cfg_src  <= s_hwdata;
               R_DST:   cfg_dst  <= s_hwdata;
               R_LEN:   cfg_len  <= s_hwdata[15:0];
               R_CTRL:  int_en   <= s_hwdata[1];
               default: ;
            endcase
         end
         // a new completion outranks a simultaneous clear
         if (ch_done)
            done_flag <= 1'b1;
         else if (commit_wr && (a_idx == R_STAT) && s_hwdata[1])
            done_flag <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dmac_ahb_slv_regs.sv
// Scoreboard bench for dmac_ahb_slv_regs: read data expected values queued at
// address phase and compared when the data phase completes.
module tb_dmac_ahb_slv_regs;

   localparam int WS = 1;

   logic        hclk = 1'b0;
   logic        hrst_n;
   logic        s_hsel, s_hwrite;
   logic [31:0] s_haddr, s_hwdata, s_hrdata;
   logic [1:0]  s_htrans, s_hresp;
   logic [3:0]  s_hprot;
   logic        s_hready;
   logic        ch_busy, ch_done;
   logic [31:0] cfg_src, cfg_dst;
   logic [15:0] cfg_len;
   logic        ch_start, irq;

   int checks = 0;
   int errors = 0;
   logic [31:0] rd_q[$];

   dmac_ahb_slv_regs #(.WAIT_STATES(WS), .ADDR_W(8)) dut (
      .hclk(hclk), .hrst_n(hrst_n), .s_hsel(s_hsel), .s_haddr(s_haddr),
      .s_htrans(s_htrans), .s_hwrite(s_hwrite), .s_hprot(s_hprot),
      .s_hwdata(s_hwdata), .s_hrdata(s_hrdata), .s_hready(s_hready),
      .s_hresp(s_hresp), .ch_busy(ch_busy), .ch_done(ch_done),
      .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
      .ch_start(ch_start), .irq(irq)
   );

   always #5 hclk = ~hclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // one single transfer; returns at the negedge of the final hready=1 cycle
   task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic err, input logic [31:0] rexp);
      int n;
      logic [31:0] e;
      @(negedge hclk);
      s_hsel = 1'b1; s_htrans = 2'b10; s_haddr = a; s_hwrite = w;
      if (!w && !err) rd_q.push_back(rexp);
      @(negedge hclk);
      s_hsel = 1'b0; s_htrans = 2'b00; s_hwdata = d;
      n = 0;
      while (!s_hready && n < 20) begin
         if (n < WS) chk("wait_resp", {30'h0, s_hresp}, 32'h0);
         else        chk("err1_resp", {30'h0, s_hresp}, 32'h1);
         n++;
         @(negedge hclk);
      end
      chk("low_cycles", n, WS + (err ? 1 : 0));
      chk("final_resp", {30'h0, s_hresp}, err ? 32'h1 : 32'h0);
      if (!w && !err) begin
         if (rd_q.size() == 0) chk("rd_q_empty", 32'h1, 32'h0);
         else begin
            e = rd_q.pop_front();
            chk("rdata", s_hrdata, e);
         end
      end
   endtask

   initial begin
      hrst_n = 1'b0; s_hsel = 0; s_haddr = 0; s_htrans = 0; s_hwrite = 0;
      s_hprot = 4'h3; s_hwdata = 0; ch_busy = 0; ch_done = 0;
      repeat (3) @(negedge hclk);
      chk("rst_hready", {31'h0, s_hready}, 32'h1);
      chk("rst_hresp", {30'h0, s_hresp}, 32'h0);
      chk("rst_hrdata", s_hrdata, 32'h0);
      chk("rst_src", cfg_src, 32'h0);
      chk("rst_start", {31'h0, ch_start}, 32'h0);
      chk("rst_irq", {31'h0, irq}, 32'h0);
      hrst_n = 1'b1;

      // scratch write/read and read-data hold across a write
      xfer(32'h0000_0000, 1, 32'h5A5A5A5A, 0, 0);
      xfer(32'h0000_0000, 0, 0, 0, 32'h5A5A5A5A);
      xfer(32'h0000_000C, 1, 32'hCAFEF00D, 0, 0);
      @(negedge hclk);
      chk("rdata_hold", s_hrdata, 32'h5A5A5A5A);
      chk("cfg_dst", cfg_dst, 32'hCAFEF00D);

      // XFER_LEN truncation
      xfer(32'h0000_0010, 1, 32'hFFFF1234, 0, 0);
      @(negedge hclk);
      chk("cfg_len", {16'h0, cfg_len}, 32'h1234);
      xfer(32'h0000_0010, 0, 0, 0, 32'h0000_1234);

      // error responses, no side effects; upper haddr bits ignored
      xfer(32'h0000_0020, 0, 0, 1, 0);
      xfer(32'h0000_0006, 1, 32'hFFFFFFFF, 1, 0);
      xfer(32'hABCD_0000, 0, 0, 0, 32'h5A5A5A5A);
      xfer(32'h0000_0004, 0, 0, 0, 32'h0);

      // start pulse, idle channel
      xfer(32'h0000_0014, 1, 32'h3, 0, 0);
      @(negedge hclk);
      chk("start_pulse", {31'h0, ch_start}, 32'h1);
      @(negedge hclk);
      chk("start_end", {31'h0, ch_start}, 32'h0);
      xfer(32'h0000_0014, 0, 0, 0, 32'h2);

      // start suppressed while busy
      ch_busy = 1'b1;
      xfer(32'h0000_0014, 1, 32'h3, 0, 0);
      @(negedge hclk);
      chk("busy_nostart0", {31'h0, ch_start}, 32'h0);
      @(negedge hclk);
      chk("busy_nostart1", {31'h0, ch_start}, 32'h0);
      xfer(32'h0000_0018, 0, 0, 0, 32'h1);
      ch_busy = 1'b0;

      // done flag, irq, W1C collision and clear
      @(negedge hclk); ch_done = 1'b1;
      @(negedge hclk); ch_done = 1'b0;
      @(negedge hclk);
      chk("irq_set", {31'h0, irq}, 32'h1);
      xfer(32'h0000_0018, 0, 0, 0, 32'h2);
      xfer(32'h0000_0018, 1, 32'h2, 0, 0);
      ch_done = 1'b1;
      @(negedge hclk); ch_done = 1'b0;
      xfer(32'h0000_0018, 0, 0, 0, 32'h2);
      xfer(32'h0000_0018, 1, 32'h2, 0, 0);
      @(negedge hclk);
      chk("irq_lag", {31'h0, irq}, 32'h1);
      @(negedge hclk);
      chk("irq_clr", {31'h0, irq}, 32'h0);
      xfer(32'h0000_0018, 0, 0, 0, 32'h0);

      // reset during the wait cycle of a write
      xfer(32'h0000_0008, 1, 32'h11111111, 0, 0);
      @(negedge hclk);
      chk("src_pre", cfg_src, 32'h11111111);
      s_hsel = 1'b1; s_htrans = 2'b10; s_haddr = 32'h8; s_hwrite = 1'b1;
      @(negedge hclk);
      s_hsel = 1'b0; s_htrans = 2'b00; s_hwdata = 32'hDEADBEEF;
      chk("mid_wait", {31'h0, s_hready}, 32'h0);
      #2 hrst_n = 1'b0;
      #1;
      chk("mid_rst_hready", {31'h0, s_hready}, 32'h1);
      chk("mid_rst_src", cfg_src, 32'h0);
      @(negedge hclk); hrst_n = 1'b1;
      repeat (2) @(negedge hclk);
      chk("post_rst_src", cfg_src, 32'h0);
      xfer(32'h0000_0008, 0, 0, 0, 32'h0);

      chk("rd_q_drained", rd_q.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
